uart_tx_mmio: RTL and testbench

Memory-mapped 8N1 UART transmitter with a write FIFO, sitting on the core's data bus beside the single-port RAM. It receives the same bus request (`i_cs`, `i_wr_en`, `i_b_en`, `i_wr_data`, `i_addr`) as the RAM, gated by the top-level address decode, and serialises bytes written by software onto `o_tx`. This gives console output in place of the 16-bit LED host register.

---
 rtl/uart_tx_mmio.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte-wide TX FIFO.
// Define UART_TX_IRQ_EN to add the o_irq port and the STATUS[8] interrupt enable.
module uart_tx_mmio #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 867
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_cs,
  input  logic        i_wr_en,
  input  logic [3:0]  i_b_en,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_addr,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
`ifdef UART_TX_IRQ_EN
  output logic        o_irq,
`endif
  output logic        o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic          tx_q, tx_d;
  logic [15:0]   bauddiv_q, bauddiv_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          access, fifo_empty, fifo_full, bit_end, pop, push_req, push;
  logic          irq_en_bit;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{i_addr[31:4], i_addr[1:0], i_b_en[3:2], i_wr_data[31:16]};

  // The ack cycle blocks a second access, so a held i_cs costs two cycles per push.
  assign access     = i_cs && !ack_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign bit_end    = (baud_cnt_q == div_lat_q);
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && bit_end));
  assign push_req   = access && i_wr_en && (i_addr[3:2] == 2'd0) && i_b_en[0];
  assign push       = push_req && (!fifo_full || pop);

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  assign irq_en_bit = irq_en_q;
  assign irq_d      = irq_en_q && fifo_empty && (state_q == S_IDLE);
  assign o_irq      = irq_q;
`else
  assign irq_en_bit = 1'b0;
`endif

  assign status = {16'h0, 6'(count_q), 1'b0, irq_en_bit, 4'h0,
                   ovf_q, fifo_empty, fifo_full, (state_q != S_IDLE)};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    div_lat_d  = div_lat_q;
    tx_d       = tx_q;
    unique case (state_q)
      S_IDLE: tx_d = 1'b1;
      S_START: begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (bit_end) begin
          state_d    = S_DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shift_q[0];
        end
      end
      S_DATA: begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      default: begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
    endcase
    // A pop (from IDLE or at the end of STOP) always starts a fresh frame with the current divisor.
    if (pop) begin
      state_d    = S_START;
      shift_d    = mem_q[rd_ptr_q];
      div_lat_d  = bauddiv_q;
      baud_cnt_d = '0;
      tx_d       = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ack_d     = access;
    rd_data_d = '0;
    bauddiv_d = bauddiv_q;
    ovf_d     = ovf_q;
`ifdef UART_TX_IRQ_EN
    irq_en_d  = irq_en_q;
`endif
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    if (access && i_wr_en) begin
      case (i_addr[3:2])
        2'd1: begin
          if (i_b_en[0] && i_wr_data[3]) ovf_d = 1'b0;
`ifdef UART_TX_IRQ_EN
          if (i_b_en[1]) irq_en_d = i_wr_data[8];
`endif
        end
        2'd2: begin
          if (i_b_en[0]) bauddiv_d[7:0]  = i_wr_data[7:0];
          if (i_b_en[1]) bauddiv_d[15:8] = i_wr_data[15:8];
        end
        default: ;
      endcase
    end else if (access) begin
      case (i_addr[3:2])
        2'd1:    rd_data_d = status;
        2'd2:    rd_data_d = {16'h0, bauddiv_q};
        default: rd_data_d = '0;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data[7:0];
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      div_lat_q  <= 16'(DEFAULT_DIV);
      tx_q       <= 1'b1;
      bauddiv_q  <= 16'(DEFAULT_DIV);
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      rd_data_q  <= '0;
`ifdef UART_TX_IRQ_EN
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      div_lat_q  <= div_lat_d;
      tx_q       <= tx_d;
      bauddiv_q  <= bauddiv_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
`ifdef UART_TX_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end

  assign o_ack     = ack_q;
  assign o_rd_data = rd_data_q;
  assign o_tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: directed bus steps plus a serial-line monitor
// that checks every frame against a queue of expected bytes.
module tb_uart_tx_mmio;

  localparam int DEFAULT_DIV = 867;

  logic        i_clk = 1'b0;
  logic        rst;
  logic        i_cs;
  logic        i_wr_en;
  logic [3:0]  i_b_en;
  logic [31:0] i_wr_data;
  logic [31:0] i_addr;
  logic        o_ack;
  logic [31:0] o_rd_data;
  logic        o_tx;
`ifdef UART_TX_IRQ_EN
  logic        o_irq;
`endif

  uart_tx_mmio #(.FIFO_DEPTH(16), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .i_clk     (i_clk),
    .rst       (rst),
    .i_cs      (i_cs),
    .i_wr_en   (i_wr_en),
    .i_b_en    (i_b_en),
    .i_wr_data (i_wr_data),
    .i_addr    (i_addr),
    .o_ack     (o_ack),
    .o_rd_data (o_rd_data),
`ifdef UART_TX_IRQ_EN
    .o_irq     (o_irq),
`endif
    .o_tx      (o_tx)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t sb[$];
  int     start_q[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_miss = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returning on a falling edge; each access occupies exactly two cycles.
  task automatic bus(input logic wr, input logic [1:0] sel, input logic [31:0] wdata,
                     input logic [3:0] ben, output logic [31:0] rdata);
    i_cs      = 1'b1;
    i_wr_en   = wr;
    i_addr    = {28'h0, sel, 2'b00};
    i_wr_data = wdata;
    i_b_en    = ben;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cs = 1'b0;
    check("bus_ack", 32'(o_ack), 32'h1);
    rdata = o_rd_data;
    @(negedge i_clk);
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] ben);
    logic [31:0] unused_rd;
    bus(1'b1, sel, data, ben, unused_rd);
  endtask

  task automatic rd_reg(input logic [1:0] sel, input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, sel, 32'h0, 4'h0, d);
    check(tag, d, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input int div);
    sb.push_back('{data: b, div: div});
    wr_reg(2'd0, {24'h0, b}, 4'h1);
  endtask

  // Serial-line monitor: samples mid-bit, compares each complete frame with the queue head.
  initial begin : monitor
    frame_t     exp_f;
    logic [9:0] bits;
    int         p, off, tgt;
    bit         aborted;
    forever begin
      @(negedge i_clk);
      if (rst === 1'b1 && o_tx === 1'b0) begin
        start_q.push_back(cyc);
        check("frame_expected", 32'(sb.size() > 0), 32'h1);
        if (sb.size() == 0) begin
          repeat (16) @(negedge i_clk);
        end else begin
          exp_f   = sb[0];
          p       = exp_f.div + 1;
          off     = 0;
          aborted = 1'b0;
          bits    = '1;
          for (int k = 0; k < 10 && !aborted; k++) begin
            tgt = k * p + p / 2;
            while (off < tgt && !aborted) begin
              @(negedge i_clk);
              off++;
              if (rst !== 1'b1) aborted = 1'b1;
            end
            bits[k] = o_tx;
          end
          if (!aborted) begin
            repeat (p - 1 - p / 2) @(negedge i_clk);
            void'(sb.pop_front());
            check("frame_bits", 32'(bits), {22'h0, 1'b1, exp_f.data, 1'b0});
          end
        end
      end
    end
  end

  initial begin : stim
    rst       = 1'b0;
    i_cs      = 1'b0;
    i_wr_en   = 1'b0;
    i_b_en    = 4'h0;
    i_wr_data = 32'h0;
    i_addr    = 32'h0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_tx", 32'(o_tx), 32'h1);
    check("rst_ack", 32'(o_ack), 32'h0);
    check("rst_rd_data", o_rd_data, 32'h0);
`ifdef UART_TX_IRQ_EN
    check("rst_irq", 32'(o_irq), 32'h0);
`endif
    rst = 1'b1;
    @(negedge i_clk);
    rd_reg(2'd1, "rst_status", 32'h0000_0004);
    rd_reg(2'd2, "rst_bauddiv", 32'(DEFAULT_DIV));

    // Default divisor, 0x55 with exact start-bit boundaries
    sb.push_back('{data: 8'h55, div: DEFAULT_DIV});
    i_cs = 1'b1; i_wr_en = 1'b1; i_addr = 32'h0; i_wr_data = 32'h55; i_b_en = 4'h1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cs = 1'b0;
    check("t1_ack", 32'(o_ack), 32'h1);
    check("t1_tx_before_start", 32'(o_tx), 32'h1);
    @(negedge i_clk);
    check("t1_start_first", 32'(o_tx), 32'h0);
    repeat (DEFAULT_DIV) @(negedge i_clk);
    check("t1_start_last", 32'(o_tx), 32'h0);
    @(negedge i_clk);
    check("t1_bit0", 32'(o_tx), 32'h1);
    repeat (2000) @(negedge i_clk);
    rd_reg(2'd1, "t1_status_busy", 32'h0000_0005);
    repeat (7000) @(negedge i_clk);
    rd_reg(2'd1, "t1_status_idle", 32'h0000_0004);

    // Back-to-back frames at BAUDDIV=3
    wr_reg(2'd2, 32'd3, 4'h3);
    start_q.delete();
    push_byte(8'hA5, 3);
    push_byte(8'h3C, 3);
    repeat (100) @(negedge i_clk);
    check("b2b_frames", 32'(start_q.size()), 32'd2);
    check("b2b_start_spacing", 32'(start_q[1] - start_q[0]), 32'd40);

    // i_cs held for four cycles: two pushes, ack on cycles 2 and 4
    sb.push_back('{data: 8'h5A, div: 3});
    sb.push_back('{data: 8'h6B, div: 3});
    i_cs = 1'b1; i_wr_en = 1'b1; i_addr = 32'h0; i_wr_data = 32'h5A; i_b_en = 4'h1;
    @(negedge i_clk);
    check("cs_hold_ack_c2", 32'(o_ack), 32'h1);
    i_wr_data = 32'h6B;
    @(negedge i_clk);
    check("cs_hold_ack_c3", 32'(o_ack), 32'h0);
    @(negedge i_clk);
    check("cs_hold_ack_c4", 32'(o_ack), 32'h1);
    @(negedge i_clk);
    check("cs_hold_ack_c5", 32'(o_ack), 32'h0);
    i_cs = 1'b0;
    rd_reg(2'd1, "cs_hold_status", 32'h0000_0401);
    rd_reg(2'd3, "rsvd_read", 32'h0);
    wr_reg(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd_reg(2'd3, "rsvd_after_write", 32'h0);
    rd_reg(2'd0, "txdata_read", 32'h0);
    repeat (100) @(negedge i_clk);
    check("cs_hold_drained", 32'(sb.size()), 32'd0);

    // Overflow while a long frame holds the FSM
    wr_reg(2'd2, 32'd200, 4'h3);
    push_byte(8'h11, 200);
    wr_reg(2'd2, 32'd3, 4'h3);
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 3);
    rd_reg(2'd1, "ovf_full_status", 32'h0000_4003);
    wr_reg(2'd0, 32'h0000_00EE, 4'h1);
    rd_reg(2'd1, "ovf_status", 32'h0000_400B);
    wr_reg(2'd1, 32'h0000_0008, 4'h1);
    rd_reg(2'd1, "ovf_cleared", 32'h0000_4003);
    repeat (2800) @(negedge i_clk);
    check("ovf_drained", 32'(sb.size()), 32'd0);
    rd_reg(2'd1, "ovf_final_status", 32'h0000_0004);

    // Reset in the middle of a data bit
    push_byte(8'h96, 3);
    push_byte(8'h0F, 3);
    repeat (3) @(negedge i_clk);
    rst = 1'b0;
    @(negedge i_clk);
    check("midframe_rst_tx", 32'(o_tx), 32'h1);
    @(negedge i_clk);
    rst = 1'b1;
    sb.delete();
    rd_reg(2'd1, "midframe_rst_status", 32'h0000_0004);
    rd_reg(2'd2, "midframe_rst_bauddiv", 32'(DEFAULT_DIV));
    repeat (60) @(negedge i_clk);
    check("midframe_rst_line_idle", 32'(o_tx), 32'h1);

    // Interrupt enable
    wr_reg(2'd2, 32'd3, 4'h3);
`ifdef UART_TX_IRQ_EN
    wr_reg(2'd1, 32'h0000_0100, 4'h2);
    check("irq_idle_high", 32'(o_irq), 32'h1);
    rd_reg(2'd1, "irq_en_readback", 32'h0000_0104);
    push_byte(8'hC3, 3);
    check("irq_busy_low", 32'(o_irq), 32'h0);
    repeat (40) @(negedge i_clk);
    check("irq_at_idle_entry", 32'(o_irq), 32'h0);
    @(negedge i_clk);
    check("irq_rise", 32'(o_irq), 32'h1);
`else
    wr_reg(2'd1, 32'h0000_0100, 4'h2);
    rd_reg(2'd1, "irq_bit_absent", 32'h0000_0004);
    push_byte(8'hC3, 3);
    repeat (41) @(negedge i_clk);
`endif

    repeat (50) @(negedge i_clk);
    check("final_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
